mc_ctr: RTL
===========

Name: mc_ctr

Overview:
- Multi-cycle control FSM for the MIPS core. It replaces single-cycle opcode decode with a sequenced controller that shares one ALU and one unified memory port across the cycles of each instruction.
- Drives the PC/IR/register-file/ALU-mux enables of the multi-cycle datapath.
- Waits on a memory ready handshake during instruction fetch, data load and data store.
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.

Parameters:
- CNT_W, 32, width of performance counters (used only with the optional feature).

Ports:
- clk  input  1  core clock, rising edge
- rst_n  input  1  synchronous active-low reset
- opCode  input  6  IR[31:26]; valid from DECODE onward
- memReady  input  1  memory completes the current read/write this cycle
- pcWrite  output  1  unconditional PC load
- pcWriteCond  output  1  PC load if ALU zero
- pcSource  output  2  00 ALU result, 01 ALUOut register, 10 jump target
- iorD  output  1  memory address: 0 = PC, 1 = ALUOut
- memRead  output  1  memory read request
- memWrite  output  1  memory write request
- irWrite  output  1  IR load
- memToReg  output  1  register write data: 1 = MDR, 0 = ALUOut
- regDst  output  1  destination register: 1 = rd, 0 = rt
- regWrite  output  1  register file write
- aluSrcA  output  1  0 = PC, 1 = register A
- aluSrcB  output  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate <<2
- aluop  output  2  00 add, 01 sub, 10 funct-decoded
- instrDone  output  1  one-cycle pulse when an instruction retires
- badOp  output  1  one-cycle pulse when an unsupported opcode is seen in DECODE
- state  output  4  current state encoding, for debug

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low: rst_n = 0 sampled on a clk rising edge forces state to IDLE. This applies mid-instruction too, including mid-wait: any in-flight memory request is dropped at once.
- Reset values: all control outputs 0, aluop 00, pcSource 00, aluSrcB 00, state = IDLE.
- State encoding:
  - IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, WBMEM 5, MEMWR 6
  - EXR 7, WBR 8, BEQ 9, JMP 10, EXI 11, WBI 12
  - Codes 13–15 are illegal; they decode to all-zero outputs and return to FETCH on the next cycle.
- Output timing: outputs are a combinational decode of the state register (Moore). The exceptions are irWrite, pcWrite in FETCH and instrDone, which are additionally gated by memReady.
- Any output not listed for a state below is 0.
- State outputs and transitions:
  - IDLE: → FETCH unconditionally.
  - FETCH: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluop=00, pcSource=00; irWrite=pcWrite=memReady. Stays while memReady=0; → DECODE when memReady=1.
  - DECODE: aluSrcA=0, aluSrcB=11, aluop=00 (branch target computed into ALUOut). Next state by opCode: lw/sw → MEMADR, R-type → EXR, beq → BEQ, j → JMP, addi → EXI. Any other opcode → FETCH with badOp=1.
  - MEMADR: aluSrcA=1, aluSrcB=10, aluop=00. → MEMRD (lw) or MEMWR (sw).
  - MEMRD: memRead=1, iorD=1. Waits on memReady; → WBMEM.
  - WBMEM: regWrite=1, memToReg=1, regDst=0, instrDone=1. → FETCH.
  - MEMWR: memWrite=1, iorD=1; instrDone=memReady. Waits on memReady; → FETCH.
  - EXR: aluSrcA=1, aluSrcB=00, aluop=10. → WBR.
  - WBR: regWrite=1, regDst=1, memToReg=0, instrDone=1. → FETCH.
  - BEQ: aluSrcA=1, aluSrcB=00, aluop=01, pcWriteCond=1, pcSource=01, instrDone=1. → FETCH.
  - JMP: pcWrite=1, pcSource=10, instrDone=1. → FETCH.
  - EXI: aluSrcA=1, aluSrcB=10, aluop=00. → WBI.
  - WBI: regWrite=1, regDst=0, memToReg=0, instrDone=1. → FETCH.
- Latency with memReady held at 1 (cycles, FETCH to retire): R-type 4, lw 5, sw 4, beq 3, j 3, addi 4. Each memory wait cycle adds 1.
- Request stability: memRead and memWrite stay asserted and stable for the whole wait; the address select (iorD) does not change during it.
- opCode is ignored outside DECODE.

Optional Feature:
- Macro: MC_CTR_PERF_CNT_EN.
- When defined, the block adds two outputs:
  - cycleCount [CNT_W-1:0]: increments every cycle that is not IDLE.
  - instrCount [CNT_W-1:0]: increments on each instrDone.
  - Both clear to 0 on reset and wrap modulo 2^CNT_W.
- When undefined, neither port nor counter logic exists.

Test Plan:
- Reset then R-type: opCode=000000, memReady=1 → states 0,1,2,7,8,1; regWrite=1 with regDst=1 only in WBR; instrDone pulses once, 4 cycles after first FETCH.
- lw with 3-cycle fetch wait and 2-cycle data wait: memReady low 3 cycles in FETCH, low 2 in MEMRD → irWrite rises only on the FETCH exit cycle; WBMEM reached after 5+3+2 = 10 cycles; memRead held high throughout both waits.
- sw then beq: sw → MEMWR asserts memWrite=1, iorD=1, never regWrite. beq → BEQ asserts pcWriteCond=1, pcSource=01, aluop=01, and retires in 3 cycles.
- j and addi: j → JMP pcWrite=1, pcSource=10. addi 001000 → EXI aluSrcB=10, then WBI regWrite=1, regDst=0.
- Illegal opcode 111111 in DECODE → badOp=1 for one cycle, next state FETCH, no write enables asserted. rst_n=0 during MEMRD wait → next cycle state=IDLE, all outputs 0.
- With MC_CTR_PERF_CNT_EN: run R-type, lw, j back-to-back with memReady=1 → instrCount=3, cycleCount=12 at the third retire cycle.

Source files
------------

// File: rtl/mc_ctr.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute over a shared ALU and memory port.
// Optional performance counters are enabled with `define MC_CTR_PERF_CNT_EN.
module mc_ctr #(
  parameter int CNT_W = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opCode,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic [1:0] pcSource,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       memToReg,
  output logic       regDst,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluop,
  output logic       instrDone,
  output logic       badOp,
  output logic [3:0] state
`ifdef MC_CTR_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycleCount,
  output logic [CNT_W-1:0] instrCount
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    WBMEM  = 4'd5,
    MEMWR  = 4'd6,
    EXR    = 4'd7,
    WBR    = 4'd8,
    BEQ    = 4'd9,
    JMP    = 4'd10,
    EXI    = 4'd11,
    WBI    = 4'd12
  } stateT;

  stateT stateQ;
  // opCode is only valid in DECODE, so the lw/sw choice is captured there for MEMADR.
  logic  isStore;

  assign state = stateQ;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ  <= IDLE;
      isStore <= 1'b0;
    end else begin
      case (stateQ)
        IDLE:   stateQ <= FETCH;
        FETCH:  if (memReady) stateQ <= DECODE;
        DECODE: begin
          isStore <= (opCode == OP_SW);
          case (opCode)
            OP_LW, OP_SW: stateQ <= MEMADR;
            OP_RTYPE:     stateQ <= EXR;
            OP_BEQ:       stateQ <= BEQ;
            OP_J:         stateQ <= JMP;
            OP_ADDI:      stateQ <= EXI;
            default:      stateQ <= FETCH;
          endcase
        end
        MEMADR: stateQ <= isStore ? MEMWR : MEMRD;
        MEMRD:  if (memReady) stateQ <= WBMEM;
        MEMWR:  if (memReady) stateQ <= FETCH;
        EXR:    stateQ <= WBR;
        EXI:    stateQ <= WBI;
        default: stateQ <= FETCH;
      endcase
    end
  end

  always_comb begin
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    pcSource    = '0;
    iorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    irWrite     = 1'b0;
    memToReg    = 1'b0;
    regDst      = 1'b0;
    regWrite    = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = '0;
    aluop       = '0;
    instrDone   = 1'b0;
    badOp       = 1'b0;
    case (stateQ)
      FETCH: begin
        memRead = 1'b1;
        aluSrcB = 2'b01;
        irWrite = memReady;
        pcWrite = memReady;
      end
      DECODE: begin
        aluSrcB = 2'b11;
        badOp   = !(opCode inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI});
      end
      MEMADR, EXI: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
      end
      MEMRD: begin
        memRead = 1'b1;
        iorD    = 1'b1;
      end
      WBMEM: begin
        regWrite  = 1'b1;
        memToReg  = 1'b1;
        instrDone = 1'b1;
      end
      MEMWR: begin
        memWrite  = 1'b1;
        iorD      = 1'b1;
        instrDone = memReady;
      end
      EXR: begin
        aluSrcA = 1'b1;
        aluop   = 2'b10;
      end
      WBR: begin
        regWrite  = 1'b1;
        regDst    = 1'b1;
        instrDone = 1'b1;
      end
      BEQ: begin
        aluSrcA     = 1'b1;
        aluop       = 2'b01;
        pcWriteCond = 1'b1;
        pcSource    = 2'b01;
        instrDone   = 1'b1;
      end
      JMP: begin
        pcWrite   = 1'b1;
        pcSource  = 2'b10;
        instrDone = 1'b1;
      end
      WBI: begin
        regWrite  = 1'b1;
        instrDone = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef MC_CTR_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycleCount <= '0;
      instrCount <= '0;
    end else begin
      if (stateQ != IDLE) cycleCount <= cycleCount + CNT_W'(1);
      if (instrDone)      instrCount <= instrCount + CNT_W'(1);
    end
  end
`endif

endmodule
